// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that shares one combinational shift+ALU datapath between
// two requesters, one operation in flight at a time.
module alu_share_ctrl #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [1:0]       req_sh0,
    input  logic [1:0]       req_sh1,
    input  logic             req_dir0,
    input  logic             req_dir1,
    output logic [W-1:0]     dp_a,
    output logic [W-1:0]     dp_b,
    output logic [2:0]       dp_alu_ctrl,
    output logic [1:0]       dp_bshift,
    output logic             dp_select,
    input  logic [W-1:0]     dp_result,
    input  logic [3:0]       dp_flags,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid[i] & ready[i].
    // req_ready is offered only in IDLE (and never during reset); rsp_valid is
    // held in RESP until the owner's rsp_ready, with data stable meanwhile.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_owner;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2:0]       r_op;
    logic [1:0]       r_sh;
    logic             r_dir;
    logic [W-1:0]     r_result;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_count;
    logic             w_grant;
    logic             w_accept;
    logic             w_done;

    // Both requesting: the one not served last; otherwise whoever asks.
    assign w_grant  = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    assign w_accept = (r_state == IDLE) && rst_n && (req_valid != 2'b00);
    assign w_done   = (r_state == RESP) && rsp_ready[r_owner];

    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (r_state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready[w_grant] = rst_n;
                    w_next             = ISSUE;
                end
            end
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_sh     <= '0;
            r_dir    <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_grant;
                r_last  <= w_grant;
                r_a     <= w_grant ? req_a1   : req_a0;
                r_b     <= w_grant ? req_b1   : req_b0;
                r_op    <= w_grant ? req_op1  : req_op0;
                r_sh    <= w_grant ? req_sh1  : req_sh0;
                r_dir   <= w_grant ? req_dir1 : req_dir0;
            end
            if (r_state == CAPTURE) begin
                r_result <= dp_result;
                r_flags  <= dp_flags;
            end
            if (w_done) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Datapath inputs come straight from the command registers so they hold until the next accept.
    assign dp_a        = r_a;
    assign dp_b        = r_b;
    assign dp_alu_ctrl = r_op;
    assign dp_bshift   = r_sh;
    assign dp_select   = r_dir;
    assign rsp_result  = r_result;
    assign rsp_flags   = r_flags;
    assign busy        = (r_state != IDLE);
    assign op_count    = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural datapath stand-in, a cycle-level reference
// model checked every cycle, and directed plus randomized scenarios.
module tb_alu_share_ctrl;

    localparam int W     = 5;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [W-1:0]     req_a0, req_a1, req_b0, req_b1;
    logic [2:0]       req_op0, req_op1;
    logic [1:0]       req_sh0, req_sh1;
    logic             req_dir0, req_dir1;
    logic [W-1:0]     dp_a, dp_b;
    logic [2:0]       dp_alu_ctrl;
    logic [1:0]       dp_bshift;
    logic             dp_select;
    logic [W-1:0]     dp_result;
    logic [3:0]       dp_flags;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [W-1:0]     rsp_result;
    logic [3:0]       rsp_flags;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .req_sh0(req_sh0), .req_sh1(req_sh1),
        .req_dir0(req_dir0), .req_dir1(req_dir1),
        .dp_a(dp_a), .dp_b(dp_b), .dp_alu_ctrl(dp_alu_ctrl), .dp_bshift(dp_bshift),
        .dp_select(dp_select), .dp_result(dp_result), .dp_flags(dp_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count), .o_dbg_state(dbg_state)
    );

    // Datapath stand-in: shift a, then ALU with b; returns {N,Z,C,V,result}.
    function automatic logic [8:0] dp_fn(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] op, input logic [1:0] sh,
                                         input logic dir);
        logic [4:0] s, r;
        logic [5:0] t;
        logic       c, v;
        s = dir ? (a >> sh) : (a << sh);
        c = 1'b0;
        v = 1'b0;
        t = 6'd0;
        case (op)
            3'd0: begin t = {1'b0, s} + {1'b0, b}; r = t[4:0]; c = t[5];
                        v = (s[4] == b[4]) && (r[4] != s[4]); end
            3'd1: begin t = {1'b0, s} - {1'b0, b}; r = t[4:0]; c = t[5];
                        v = (s[4] != b[4]) && (r[4] != s[4]); end
            3'd2: r = s & b;
            3'd3: r = s | b;
            3'd4: r = s ^ b;
            3'd5: r = ~(s | b);
            3'd6: r = s;
            default: r = b;
        endcase
        return {r[4], (r == 5'd0), c, v, r};
    endfunction

    assign {dp_flags, dp_result} = dp_fn(dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic grant_of(input logic [1:0] rv, input logic last);
        return (rv == 2'b11) ? ~last : rv[1];
    endfunction

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    bit          m_valid;
    bit          m_busy;
    int          m_age;
    bit          m_owner;
    bit          m_last;
    int          m_count;
    logic [15:0] m_cmd;
    logic [4:0]  m_res;
    logic [3:0]  m_flags;
    bit          s_rst;
    logic [1:0]  s_rv, s_rr;
    logic [15:0] s_cmd0, s_cmd1;
    int          acc_cyc[$];
    int          acc_port[$];

    always @(negedge clk) begin
        s_rst  <= rst_n;
        s_rv   <= req_valid;
        s_rr   <= rsp_ready;
        s_cmd0 <= {req_a0, req_b0, req_op0, req_sh0, req_dir0};
        s_cmd1 <= {req_a1, req_b1, req_op1, req_sh1, req_dir1};
        if (m_valid) begin
            check_eq("req_ready", req_ready,
                     (rst_n && !m_busy && req_valid != 2'b00) ?
                     (grant_of(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00);
            check_eq("rsp_valid", rsp_valid,
                     (m_busy && m_age == 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
            check_eq("busy", busy, m_busy);
            check_eq("op_count", op_count, m_count);
            check_eq("dp_cmd", {dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select}, m_cmd);
            check_eq("rsp_data", {rsp_flags, rsp_result}, {m_flags, m_res});
            if (rst_n && (req_valid & req_ready) != 2'b00) begin
                acc_cyc.push_back(cyc);
                acc_port.push_back(int'(req_ready[1]));
            end
        end
    end

    always @(posedge clk) begin
        if (!s_rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_count <= 0;
            m_cmd   <= '0;
            m_res   <= '0;
            m_flags <= '0;
        end else if (!m_busy) begin
            if (s_rv != 2'b00) begin
                m_owner <= grant_of(s_rv, m_last);
                m_last  <= grant_of(s_rv, m_last);
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_cmd   <= grant_of(s_rv, m_last) ? s_cmd1 : s_cmd0;
            end
        end else begin
            if (m_age == 2)
                {m_flags, m_res} <= dp_fn(m_cmd[15:11], m_cmd[10:6], m_cmd[5:3], m_cmd[2:1], m_cmd[0]);
            if (m_age == 3) begin
                if (s_rr[m_owner]) begin
                    m_busy  <= 1'b0;
                    m_count <= (m_count + 1) % (1 << CNT_W);
                end
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rand_port(input int p);
        if (p == 0) begin
            req_a0 = 5'($urandom_range(0, 31)); req_b0 = 5'($urandom_range(0, 31));
            req_op0 = 3'($urandom_range(0, 7)); req_sh0 = 2'($urandom_range(0, 3));
            req_dir0 = 1'($urandom_range(0, 1));
        end else begin
            req_a1 = 5'($urandom_range(0, 31)); req_b1 = 5'($urandom_range(0, 31));
            req_op1 = 3'($urandom_range(0, 7)); req_sh1 = 2'($urandom_range(0, 3));
            req_dir1 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_accept(input int p);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                @(posedge clk);
                #1;
                req_valid[p] = 1'b0;
                found = 1'b1;
            end
        end
        if (!found) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic send(input int p);
        req_valid[p] = 1'b1;
        wait_accept(p);
    endtask

    task automatic wait_done(input bit rand_rdy);
        bit found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                @(posedge clk);
                #1;
                found = 1'b1;
            end else if (rand_rdy) begin
                @(posedge clk);
                #1;
                rsp_ready = 2'($urandom_range(0, 3));
            end
        end
        if (!found) check_eq("done_timeout", 0, 1);
    endtask

    task automatic wait_rsp_valid(input int p);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rsp_valid[p]) found = 1'b1;
        end
        if (!found) check_eq("rsp_valid_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    int         n_acc;
    int         c0;
    logic [1:0] r;
    logic [8:0] exp9;

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        rand_port(0);
        rand_port(1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_op_count", op_count, 0);
        check_eq("reset_rsp", {rsp_valid, rsp_flags, rsp_result}, 0);
        check_eq("reset_dp", {dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select}, 0);

        // Contention: both valid continuously.
        @(posedge clk);
        #1;
        acc_cyc.delete();
        acc_port.delete();
        req_valid = 2'b11;
        n_acc = 0;
        for (int k = 0; k < 100 && n_acc < 8; k++) begin
            @(negedge clk);
            r = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (r[0]) begin n_acc++; rand_port(0); end
            if (r[1]) begin n_acc++; rand_port(1); end
        end
        req_valid = 2'b00;
        check_eq("contention_accepts", n_acc, 8);
        wait_done(1'b0);
        for (int i = 0; i < 8 && i < acc_port.size(); i++)
            check_eq("grant_seq", acc_port[i], i % 2);
        for (int i = 1; i < 8 && i < acc_cyc.size(); i++)
            check_eq("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 4);

        // Single directed op on port 0 (XOR code 4).
        c0 = m_count;
        req_a0 = 5'b00011; req_b0 = 5'b00101; req_op0 = 3'd4; req_sh0 = 2'd1; req_dir0 = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check_eq("t1_req_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("t1_issue_dp", {dp_a, dp_bshift, dp_select}, {5'd3, 2'd1, 1'b0});
        @(negedge clk);
        check_eq("t1_capture_rsp_valid", rsp_valid, 2'b00);
        @(negedge clk);
        check_eq("t1_rsp_valid", rsp_valid, 2'b01);
        check_eq("t1_rsp_result", rsp_result, 5'b00011);
        check_eq("t1_rsp_flags", rsp_flags, 4'b0000);
        @(posedge clk);
        #1;
        check_eq("t1_op_count", op_count, (c0 + 1) % (1 << CNT_W));

        // Backpressure on port 1 with port 0 waiting.
        rsp_ready = 2'b01;
        rand_port(1);
        exp9 = dp_fn(req_a1, req_b1, req_op1, req_sh1, req_dir1);
        send(1);
        wait_rsp_valid(1);
        c0 = m_count;
        rand_port(0);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", rsp_valid, 2'b10);
            check_eq("bp_rsp_data", {rsp_flags, rsp_result}, exp9);
            check_eq("bp_req_ready", req_ready, 2'b00);
            check_eq("bp_op_count", op_count, c0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        wait_done(1'b0);
        wait_accept(0);
        wait_done(1'b0);

        // Non-owner ready must not complete.
        rsp_ready = 2'b10;
        rand_port(0);
        send(0);
        wait_rsp_valid(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("nonowner_state", dbg_state, 2'd3);
            check_eq("nonowner_rsp_valid", rsp_valid, 2'b01);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b01;
        wait_done(1'b0);

        // Randomized traffic with random response backpressure.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            rsp_ready = 2'($urandom_range(0, 3));
            if (mode < 2) begin
                rand_port(mode);
                send(mode);
            end else begin
                rand_port(0);
                rand_port(1);
                req_valid = 2'b11;
                for (int k = 0; k < 300 && req_valid != 2'b00; k++) begin
                    @(negedge clk);
                    r = req_valid & req_ready;
                    @(posedge clk);
                    #1;
                    req_valid = req_valid & ~r;
                    rsp_ready = 2'($urandom_range(0, 3));
                end
                check_eq("rand_both_accepted", req_valid, 2'b00);
                req_valid = 2'b00;
            end
            wait_done(1'b1);
        end
        rsp_ready = 2'b11;

        // Reset during CAPTURE, then arbitration and counter wrap from scratch.
        rand_port(1);
        send(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_port(0);
        rand_port(1);
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("midrst_rsp", {rsp_valid, rsp_flags, rsp_result}, 0);
        check_eq("midrst_busy_count", {busy, op_count}, 0);
        check_eq("midrst_dp", {dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select}, 0);
        check_eq("midrst_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_done(1'b0);
        check_eq("wrap_seq_1", op_count, 1);
        wait_accept(1);
        wait_done(1'b0);
        check_eq("wrap_seq_2", op_count, 2);
        for (int i = 0; i < 3; i++) begin
            rand_port(i % 2);
            send(i % 2);
            wait_done(1'b0);
            check_eq("wrap_seq_tail", op_count, (3 + i) % 4);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port scheduler sharing one shift + ALU datapath (5-bit left/right shifter, 2:1 shift-direction mux, 5-bit ALU with NZCV flags) between two requesters. It arbitrates round-robin, registers the winning command, drives the datapath operand/control inputs for one cycle, captures result and flags, and returns them on the winner's response port with a valid/ready handshake. It sits between the command sources and the datapath top level; the datapath itself is purely combinational.

## Interface
Parameters
- `W`, 5: operand/result width; must match the datapath.
- `CNT_W`, 8: width of the completed-operation counter.

Ports
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid[1:0]`  in  2  command valid, one bit per requester (index 0/1).
- `req_ready[1:0]`  out  2  command accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_a0`, `req_a1`  in  W  operand A per requester (shifted operand).
- `req_b0`, `req_b1`  in  W  operand B per requester.
- `req_op0`, `req_op1`  in  3  ALU control code, passed through unmodified.
- `req_sh0`, `req_sh1`  in  2  shift amount 0–3.
- `req_dir0`, `req_dir1`  in  1  0 = left shift, 1 = right shift.
- `dp_a`, `dp_b`  out  W  datapath operands.
- `dp_alu_ctrl`  out  3  datapath ALU control.
- `dp_bshift`  out  2  datapath shift amount.
- `dp_select`  out  1  datapath shift-direction select.
- `dp_result`  in  W  datapath result (combinational from `dp_*`).
- `dp_flags`  in  4  datapath flags {N,Z,C,V}.
- `rsp_valid[1:0]`  out  2  response valid per requester.
- `rsp_ready[1:0]`  in  2  response consumed when `rsp_valid[i] & rsp_ready[i]`.
- `rsp_result`  out  W  captured result (shared, qualified by `rsp_valid`).
- `rsp_flags`  out  4  captured flags.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  CNT_W  number of completed responses, wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any `req_valid`, grant one requester. `req_ready[g]` = 1 for the grantee only, combinationally, in IDLE only; all other `req_ready` = 0. On the handshake, register {a, b, op, sh, dir, owner = g} and go to ISSUE.
- Arbitration: round-robin. `last` pointer resets to 1, so requester 0 wins the first contest. With both requesting, grant `~last`. With one requesting, grant it regardless of `last`. `last` updates to g on each accept.
- ISSUE: `dp_*` driven from the command registers (they hold these values in every state until the next accept). Go to CAPTURE.
- CAPTURE: register `dp_result` into `rsp_result` and `dp_flags` into `rsp_flags`. Go to RESP.
- RESP: `rsp_valid[owner]` = 1, the other bit 0. On `rsp_ready[owner]`: increment `op_count` and go to IDLE. `rsp_ready` of the non-owner is ignored.
- No new command is accepted until the response handshake completes: one operation in flight at a time.
- `dp_select` = registered dir. `dp_bshift` = registered sh. No arithmetic is done in this block; flags are passed through as the datapath produces them.

## Timing
- Reset (`rst_n` low at a rising edge):
  - state = IDLE, `last` = 1;
  - `req_ready` = 0 while reset is asserted;
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_flags` = 0;
  - all `dp_*` = 0, `busy` = 0, `op_count` = 0.
- Reset mid-operation aborts the command; no response is produced.
- Latency: accept at edge N; ISSUE during cycle N+1; CAPTURE during N+2; `rsp_valid` high from N+3.
- Minimum initiation interval is 4 cycles, when `rsp_ready` is already high in the first RESP cycle.
- Responses stall indefinitely while `rsp_ready[owner]` = 0. `rsp_result` and `rsp_flags` stay stable during the stall.
- A request arriving during a busy period waits; `req_valid` must hold until its ready.
- Response handshake and a new request in the same cycle: the request is seen in the following (IDLE) cycle, never the same cycle.
- `op_count` wraps from 2^CNT_W−1 to 0.

## Test plan
- Single op, port 0: a=5'b00011, sh=1, dir=0, b=5'b00101, op set to the ALU's XOR code, `rsp_ready` held high.
  - Required: `req_ready[0]` in cycle 0; `dp_a`=3, `dp_bshift`=1, `dp_select`=0 in ISSUE.
  - Required: `rsp_valid[0]` at cycle 3 with `rsp_result` equal to `dp_result` sampled in CAPTURE (0b00011), flags matching; `op_count`=1.
- Contention: both ports valid continuously with distinct operands.
  - Required: grants 0,1,0,1 with responses routed to the matching `rsp_valid` bit.
  - Required: every accept exactly 4 cycles apart.
- Backpressure: hold `rsp_ready[1]`=0 for 10 cycles while a port-1 op is in RESP.
  - Required: `rsp_valid[1]` and `rsp_result` stable throughout.
  - Required: `req_ready` = 0 throughout, even with `req_valid[0]` high; `op_count` unchanged until release.
- Non-owner ready: owner = 0, `rsp_ready`=2'b10.
  - Required: no completion, state stays RESP.
- Reset mid-op: deassert `rst_n` during CAPTURE.
  - Required: next cycle all outputs are at their reset values, and no `rsp_valid` pulse follows.
  - Required: after release, requester 0 wins a simultaneous request.
- Counter wrap with CNT_W=2: complete 5 ops.
  - Required: `op_count` sequence 1,2,3,0,1.
